// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl (with package riscv_defs)
// Purpose  : RV32I 5-stage forwarding selects, load-use stall, memory-wait
//            freeze and branch flush. Optional counters: HAZARD_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

package riscv_defs;
  localparam int NB_WORD    = 32;
  localparam int NB_OPERAND = 5;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
endpackage

module hazard_ctrl
  import riscv_defs::*;
#(
  parameter int NB_PERF = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_id_valid,
  input  logic [NB_WORD-1:0] i_id_instruction,
  input  logic               i_mem_ready,
  input  logic               i_branch_taken,
  output logic [1:0]         o_forward_rs1,
  output logic [1:0]         o_forward_rs2,
  output logic               o_stall_if,
  output logic               o_stall_id,
  output logic               o_bubble_ex,
  output logic               o_flush_if_id,
  output logic               o_freeze
`ifdef HAZARD_PERF_EN
  ,
  output logic [NB_PERF-1:0] o_stall_cycles,
  output logic [NB_PERF-1:0] o_flush_count,
  output logic [NB_PERF-1:0] o_load_use_count
`endif
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [6:0]            w_opcode;
  logic [NB_OPERAND-1:0] w_rd, w_rs1, w_rs2;
  logic                  w_uses_rs1, w_uses_rs2, w_writes_rd, w_is_load, w_is_mem;

  logic                  r_ex_valid, r_ex_wr, r_ex_ld, r_ex_mem;
  logic [NB_OPERAND-1:0] r_ex_rd;
  logic                  r_mem_valid, r_mem_wr, r_mem_ld, r_mem_mem;
  logic [NB_OPERAND-1:0] r_mem_rd;

  logic w_ex_hit_rs1, w_ex_hit_rs2, w_mem_hit_rs1, w_mem_hit_rs2;
  logic w_load_use, w_mem_wait;
  logic w_unused_bits;

  assign w_opcode = i_id_instruction[6:0];
  assign w_rd     = i_id_instruction[11:7];
  assign w_rs1    = i_id_instruction[19:15];
  assign w_rs2    = i_id_instruction[24:20];

  assign w_unused_bits = ^{i_id_instruction[31:25], i_id_instruction[14:12], r_mem_ld};

  always_comb begin
    w_uses_rs1  = 1'b0;
    w_uses_rs2  = 1'b0;
    w_writes_rd = 1'b0;
    w_is_load   = 1'b0;
    w_is_mem    = 1'b0;
    case (w_opcode)
      LUI, AUIPC, JAL: w_writes_rd = 1'b1;
      JALR: begin
        w_uses_rs1  = 1'b1;
        w_writes_rd = 1'b1;
      end
      BRANCH: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      LOAD: begin
        w_uses_rs1  = 1'b1;
        w_writes_rd = 1'b1;
        w_is_load   = 1'b1;
        w_is_mem    = 1'b1;
      end
      STORE: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
        w_is_mem   = 1'b1;
      end
      OP_IMM: begin
        w_uses_rs1  = 1'b1;
        w_writes_rd = 1'b1;
      end
      OP: begin
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
        w_writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  // A load in EX has no result yet, so it never forwards from EX.
  assign w_ex_hit_rs1  = r_ex_valid & r_ex_wr & ~r_ex_ld & (r_ex_rd == w_rs1) & (w_rs1 != '0);
  assign w_ex_hit_rs2  = r_ex_valid & r_ex_wr & ~r_ex_ld & (r_ex_rd == w_rs2) & (w_rs2 != '0);
  assign w_mem_hit_rs1 = r_mem_valid & r_mem_wr & (r_mem_rd == w_rs1) & (w_rs1 != '0);
  assign w_mem_hit_rs2 = r_mem_valid & r_mem_wr & (r_mem_rd == w_rs2) & (w_rs2 != '0);

  always_comb begin
    o_forward_rs1 = 2'b00;
    o_forward_rs2 = 2'b00;
    if (!i_reset && i_id_valid && w_uses_rs1) begin
      if (w_ex_hit_rs1)       o_forward_rs1 = 2'b10;
      else if (w_mem_hit_rs1) o_forward_rs1 = 2'b01;
    end
    if (!i_reset && i_id_valid && w_uses_rs2) begin
      if (w_ex_hit_rs2)       o_forward_rs2 = 2'b10;
      else if (w_mem_hit_rs2) o_forward_rs2 = 2'b01;
    end
  end

  assign w_load_use = i_id_valid & r_ex_valid & r_ex_ld & (r_ex_rd != '0) &
                      ((w_uses_rs1 & (w_rs1 == r_ex_rd)) | (w_uses_rs2 & (w_rs2 == r_ex_rd)));
  assign w_mem_wait = r_mem_valid & r_mem_mem & ~i_mem_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= RUN;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = RUN;
    o_stall_if    = 1'b0;
    o_stall_id    = 1'b0;
    o_bubble_ex   = 1'b0;
    o_flush_if_id = 1'b0;
    o_freeze      = 1'b0;
    if (!i_reset) begin
      if (w_mem_wait) begin
        o_freeze   = 1'b1;
        o_stall_if = 1'b1;
        o_stall_id = 1'b1;
      end else if (i_branch_taken) begin
        o_flush_if_id = 1'b1;
        o_bubble_ex   = 1'b1;
      end else if (w_load_use) begin
        o_stall_if  = 1'b1;
        o_stall_id  = 1'b1;
        o_bubble_ex = 1'b1;
      end
      // The cycle memory becomes ready behaves as an ordinary RUN cycle.
      case (r_state)
        RUN, MEM_WAIT: begin
          if (w_mem_wait)          w_state_next = MEM_WAIT;
          else if (i_branch_taken) w_state_next = RUN;
          else if (w_load_use)     w_state_next = LOAD_STALL;
          else                     w_state_next = RUN;
        end
        LOAD_STALL: w_state_next = w_mem_wait ? MEM_WAIT : RUN;
        default:    w_state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ex_valid  <= 1'b0;
      r_ex_rd     <= '0;
      r_ex_wr     <= 1'b0;
      r_ex_ld     <= 1'b0;
      r_ex_mem    <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_rd    <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_ld    <= 1'b0;
      r_mem_mem   <= 1'b0;
    end else if (!o_freeze) begin
      r_mem_valid <= r_ex_valid;
      r_mem_rd    <= r_ex_rd;
      r_mem_wr    <= r_ex_wr;
      r_mem_ld    <= r_ex_ld;
      r_mem_mem   <= r_ex_mem;
      if (o_bubble_ex || !i_id_valid) begin
        r_ex_valid <= 1'b0;
        r_ex_rd    <= '0;
        r_ex_wr    <= 1'b0;
        r_ex_ld    <= 1'b0;
        r_ex_mem   <= 1'b0;
      end else begin
        r_ex_valid <= 1'b1;
        r_ex_rd    <= w_rd;
        r_ex_wr    <= w_writes_rd;
        r_ex_ld    <= w_is_load;
        r_ex_mem   <= w_is_mem;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [NB_PERF-1:0] r_stall_cycles, r_flush_count, r_load_use_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_stall_cycles   <= '0;
      r_flush_count    <= '0;
      r_load_use_count <= '0;
    end else begin
      if (o_stall_if && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (o_flush_if_id && (r_flush_count != '1))
        r_flush_count <= r_flush_count + 1'b1;
      if ((r_state != LOAD_STALL) && (w_state_next == LOAD_STALL) && (r_load_use_count != '1))
        r_load_use_count <= r_load_use_count + 1'b1;
    end
  end

  assign o_stall_cycles   = r_stall_cycles;
  assign o_flush_count    = r_flush_count;
  assign o_load_use_count = r_load_use_count;
`else
  logic w_unused_perf;
  assign w_unused_perf = (NB_PERF == 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: the driver queues expected outputs,
// the negedge monitor pops and compares them.
`default_nettype none

module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = 32'h0000_0013;
  logic        mem_ready = 1'b1;
  logic        br_taken = 1'b0;
  logic [1:0]  fwd1, fwd2;
  logic        stall_if, stall_id, bubble_ex, flush_if_id, freeze;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count, load_use_count;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.NB_PERF(32)) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_id_valid       (id_valid),
    .i_id_instruction (id_instr),
    .i_mem_ready      (mem_ready),
    .i_branch_taken   (br_taken),
    .o_forward_rs1    (fwd1),
    .o_forward_rs2    (fwd2),
    .o_stall_if       (stall_if),
    .o_stall_id       (stall_id),
    .o_bubble_ex      (bubble_ex),
    .o_flush_if_id    (flush_if_id),
    .o_freeze         (freeze)
`ifdef HAZARD_PERF_EN
    ,
    .o_stall_cycles   (stall_cycles),
    .o_flush_count    (flush_count),
    .o_load_use_count (load_use_count)
`endif
  );

  typedef struct {
    logic [8:0]  exp;
    string       name;
    bit          perf_chk;
    logic [31:0] e_stall;
    logic [31:0] e_flush;
    logic [31:0] e_lu;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] f_add(input logic [4:0] rd, rs1, rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] f_sub(input logic [4:0] rd, rs1, rs2);
    return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] f_lw(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] f_sw(input logic [4:0] rs2, rs1);
    return {7'b0000000, rs2, rs1, 3'b010, 5'b00000, 7'b0100011};
  endfunction

  // {fwd1, fwd2, stall_if, stall_id, bubble_ex, flush_if_id, freeze}
  function automatic logic [8:0] E(input logic [1:0] f1, f2, input bit sif, sid, bub, fl, fr);
    return {f1, f2, sif, sid, bub, fl, fr};
  endfunction

  task automatic step(input bit r, input bit v, input logic [31:0] ins, input bit rdy,
                      input bit br, input logic [8:0] e, input string nm,
                      input bit pc = 1'b0, input int es = 0, input int ef = 0, input int el = 0);
    exp_t x;
    @(posedge clk);
    #1;
    rst       = r;
    id_valid  = v;
    id_instr  = ins;
    mem_ready = rdy;
    br_taken  = br;
    x.exp      = e;
    x.name     = nm;
    x.perf_chk = pc;
    x.e_stall  = es;
    x.e_flush  = ef;
    x.e_lu     = el;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t       x;
    logic [8:0] got;
    if (sb.size() > 0) begin
      x   = sb.pop_front();
      got = {fwd1, fwd2, stall_if, stall_id, bubble_ex, flush_if_id, freeze};
      n_vec++;
      if (got !== x.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b (f1 f2 sif sid bub fl fr)", x.name, got, x.exp);
      end
`ifdef HAZARD_PERF_EN
      if (x.perf_chk) begin
        n_vec++;
        if ({stall_cycles, flush_count, load_use_count} !== {x.e_stall, x.e_flush, x.e_lu}) begin
          n_err++;
          $display("FAIL %s_perf: got %0d/%0d/%0d expected %0d/%0d/%0d", x.name,
                   stall_cycles, flush_count, load_use_count, x.e_stall, x.e_flush, x.e_lu);
        end
      end
`endif
    end
  end

  initial begin
    logic [8:0] z;
    z = 9'd0;
    // reset, including a taken branch that must stay invisible
    step(1, 1, f_add(5'd1, 5'd2, 5'd3), 1, 0, z, "reset");
    step(1, 1, f_add(5'd1, 5'd2, 5'd3), 1, 1, z, "reset_branch");
    // back-to-back EX forwarding
    step(0, 1, f_add(5'd5, 5'd1, 5'd2),   1, 0, E(2'b00, 2'b00, 0,0,0,0,0), "add_x5");
    step(0, 1, f_add(5'd6, 5'd5, 5'd5),   1, 0, E(2'b10, 2'b10, 0,0,0,0,0), "ex_fwd_both");
    // rs2 field of LW equals x5 (in MEM) but rs2 is unused
    step(0, 1, f_lw(5'd5, 5'd6, 12'd5),   1, 0, E(2'b10, 2'b00, 0,0,0,0,0), "lw_unused_rs2");
    step(0, 1, f_add(5'd7, 5'd5, 5'd1),   1, 0, E(2'b00, 2'b00, 1,1,1,0,0), "load_use_stall");
    step(0, 1, f_add(5'd7, 5'd5, 5'd1),   1, 0, E(2'b01, 2'b00, 0,0,0,0,0), "after_load_mem_fwd");
    // EX priority over MEM, x0 never forwards
    step(0, 1, f_add(5'd5, 5'd7, 5'd0),   1, 0, E(2'b10, 2'b00, 0,0,0,0,0), "add_x5_a");
    step(0, 1, f_add(5'd5, 5'd7, 5'd7),   1, 0, E(2'b01, 2'b01, 0,0,0,0,0), "mem_fwd_both");
    step(0, 1, f_sub(5'd7, 5'd5, 5'd0),   1, 0, E(2'b10, 2'b00, 0,0,0,0,0), "ex_priority");
    step(0, 1, f_add(5'd0, 5'd1, 5'd1),   1, 0, E(2'b00, 2'b00, 0,0,0,0,0), "write_x0");
    step(0, 1, f_add(5'd8, 5'd0, 5'd7),   1, 0, E(2'b00, 2'b01, 0,0,0,0,0), "read_x0");
    // store reaches MEM, memory holds off for 3 cycles
    step(0, 1, f_sw(5'd8, 5'd2),          1, 0, E(2'b00, 2'b10, 0,0,0,0,0), "sw_rs2_fwd");
    step(0, 1, f_add(5'd9, 5'd1, 5'd1),   1, 0, E(2'b00, 2'b00, 0,0,0,0,0), "add_x9");
    step(0, 1, f_add(5'd10, 5'd9, 5'd1),  0, 0, E(2'b10, 2'b00, 1,1,0,0,1), "mem_wait_1");
    step(0, 1, f_add(5'd10, 5'd9, 5'd1),  0, 0, E(2'b10, 2'b00, 1,1,0,0,1), "mem_wait_2");
    step(0, 1, f_add(5'd10, 5'd9, 5'd1),  0, 1, E(2'b10, 2'b00, 1,1,0,0,1), "mem_wait_3_br_ignored");
    step(0, 1, f_add(5'd10, 5'd9, 5'd1),  1, 0, E(2'b10, 2'b00, 0,0,0,0,0), "mem_ready_resume");
    // taken branch overrides a pending load-use
    step(0, 1, f_lw(5'd11, 5'd10, 12'd0), 1, 0, E(2'b10, 2'b00, 0,0,0,0,0), "lw_x11");
    step(0, 1, f_add(5'd12, 5'd11, 5'd0), 1, 1, E(2'b00, 2'b00, 0,0,1,1,0), "branch_over_load_use");
    step(0, 0, f_add(5'd13, 5'd11, 5'd11),1, 0, E(2'b00, 2'b00, 0,0,0,0,0), "id_invalid");
    // reset in the middle of a load-use stall
    step(0, 1, f_lw(5'd14, 5'd1, 12'd0),  1, 0, E(2'b00, 2'b00, 0,0,0,0,0), "lw_x14");
    step(0, 1, f_add(5'd15, 5'd14, 5'd14),1, 0, E(2'b00, 2'b00, 1,1,1,0,0), "load_use_2");
    step(1, 1, f_add(5'd15, 5'd14, 5'd14),1, 0, z, "reset_mid_stall", 1, 5, 1, 2);
    step(0, 1, f_add(5'd15, 5'd14, 5'd14),1, 0, z, "post_reset_no_fwd", 1, 0, 0, 0);
    step(0, 1, f_add(5'd16, 5'd15, 5'd0), 1, 0, E(2'b10, 2'b00, 0,0,0,0,0), "post_reset_ex_fwd");

    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries never checked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage RV32I core.
- Tracks destination registers of instructions in EX and MEM, and drives the decode-stage operand-forwarding selects (i_forward_rs1/i_forward_rs2 of the decode stage).
- Generates load-use stalls, memory-wait freezes and taken-branch flushes.
- Writeback needs no forwarding: the register file writes on the negative clock edge.

Parameters:
- NB_PERF, 32, width of optional performance counters.
- Widths NB_WORD (32) and NB_OPERAND (5), plus opcode constants LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, come from riscv_defs.

Ports:
- i_clock  in  1  core clock; all state updates on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_id_valid  in  1  ID stage holds a real instruction.
- i_id_instruction  in  NB_WORD  instruction currently in ID.
- i_mem_ready  in  1  data memory completed access this cycle.
- i_branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- o_forward_rs1  out  2  00 RF, 01 MEM-stage result, 10 EX ALU result.
- o_forward_rs2  out  2  same encoding as o_forward_rs1.
- o_stall_if  out  1  hold PC.
- o_stall_id  out  1  hold IF/ID register.
- o_bubble_ex  out  1  load NOP into ID/EX.
- o_flush_if_id  out  1  clear IF/ID register.
- o_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB (memory wait).

Behaviour:
- Decode from i_id_instruction opcode:
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - uses_rs2: BRANCH, STORE, OP.
  - writes_rd: LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP.
  - is_load: LOAD.
  - is_mem: LOAD, STORE.
  - Any other opcode is treated as a NOP (no use, no write).
- Tracking slots EX_S and MEM_S, each {valid, rd, writes_rd, is_load, is_mem}. Reset clears all fields.
- Slot update on posedge, in priority order:
  - o_freeze=1: both slots hold.
  - Otherwise MEM_S <= EX_S.
  - EX_S <= bubble (valid=0) if o_bubble_ex=1 or i_id_valid=0; else the decoded ID info.
- Forwarding, per source s in {rs1, rs2}, combinational:
  - 10 if EX_S.valid & writes_rd & !is_load & rd==s & s!=0.
  - Else 01 if MEM_S.valid & writes_rd & rd==s & s!=0.
  - Else 00.
  - EX has priority over MEM. Selects are forced 00 when the source is unused or i_id_valid=0.
- load_use = i_id_valid & EX_S.valid & EX_S.is_load & EX_S.rd!=0 & ((uses_rs1 & rs1==EX_S.rd) | (uses_rs2 & rs2==EX_S.rd)).
- mem_wait = MEM_S.valid & MEM_S.is_mem & !i_mem_ready.
- FSM states: RUN, LOAD_STALL, MEM_WAIT.
  - RUN: if mem_wait -> MEM_WAIT; elif i_branch_taken -> RUN (flush); elif load_use -> LOAD_STALL; else RUN.
  - LOAD_STALL: lasts exactly one cycle, then -> RUN (MEM_WAIT if mem_wait). The load is now in MEM_S, so forwarding selects 01.
  - MEM_WAIT: stays while mem_wait; on i_mem_ready=1 -> RUN in the same cycle.
- Output priority (combinational, highest first):
  1. mem_wait: o_freeze=o_stall_if=o_stall_id=1, all others 0.
  2. i_branch_taken: o_flush_if_id=1, o_bubble_ex=1, no stall.
  3. load_use: o_stall_if=o_stall_id=o_bubble_ex=1.
  4. Else all 0.
- i_branch_taken during mem_wait is ignored by this block; EX holds it frozen and re-presents it.
- Reset: all outputs 0 while i_reset=1, including when i_branch_taken=1. Slots invalid, state RUN. Reset mid-stall aborts the stall in the same cycle.
- Latency: forwarding selects and stall/flush outputs are combinational from ID inputs and registered slots; zero cycles.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds these ports:
  - o_stall_cycles  out  NB_PERF: counts cycles with o_stall_if=1.
  - o_flush_count  out  NB_PERF: counts cycles with o_flush_if_id=1.
  - o_load_use_count  out  NB_PERF: counts entries into LOAD_STALL.
- Counters are saturating, reset to 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- ADD x5 then ADD x6,x5,x5 back-to-back -> second in ID sees o_forward_rs1=o_forward_rs2=10, no stall.
- LW x5 then ADD x6,x5,x1 -> one cycle with o_stall_if=o_stall_id=o_bubble_ex=1, then o_forward_rs1=01, o_forward_rs2=00.
- ADD x5; ADD x5; SUB x7,x5,x0 -> o_forward_rs1=10 (EX priority), o_forward_rs2=00. Writes and reads of x0 never forward.
- SW reaching MEM with i_mem_ready=0 for 3 cycles -> o_freeze=1 for exactly 3 cycles, slots unchanged, resumes on ready.
- i_branch_taken=1 with a load-use pending in ID -> o_flush_if_id=1, o_bubble_ex=1, o_stall_if=0. Next cycle state RUN.
- Assert i_reset during LOAD_STALL -> all outputs 0 that cycle; after release, first ADD shows forward selects 00. With HAZARD_PERF_EN defined, counters read 0.
